mem_req_demux_1to2: RTL and testbench
=====================================

Name: mem_req_demux_1to2

Overview:
- Routes a single-master memory request stream from the RISC core to one of two slave targets: target 0 (data RAM) or target 1 (MMIO/peripherals).
- The target is chosen by one address bit.
- The selected target's response is steered back to the master.
- One transaction is outstanding at a time, with valid/ready handshakes on every channel. The block sits between the core's load/store unit and the memory/IO slaves.

Parameters:
- AW, 8, address width in bits.
- DW, 16, data width in bits.
- SEL_BIT, 7, index of the address bit that selects the target (0 = target 0, 1 = target 1); must be < AW.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- m_valid  input  1  master request valid.
- m_ready  output  1  block can accept a request.
- m_we  input  1  1 = write, 0 = read.
- m_addr  input  AW  request address.
- m_wdata  input  DW  write data.
- m_rvalid  output  1  response valid to master.
- m_rready  input  1  master accepts response.
- m_rdata  output  DW  read data (0 for writes).
- t0_valid, t1_valid  output  1 each  request valid to target 0/1.
- t0_ready, t1_ready  input  1 each  target accepts request.
- t_we  output  1  latched write enable, shared by both targets.
- t_addr  output  AW  latched address, shared.
- t_wdata  output  DW  latched write data, shared.
- t0_rvalid, t1_rvalid  input  1 each  target response valid (for both reads and write acks).
- t0_rdata, t1_rdata  input  DW each  target read data.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- States: IDLE, REQ, RESP, DONE. Registered latches: we_q, addr_q, wdata_q, sel_q, rdata_q.
- Reset (async, any state, mid-transaction included):
  - State goes to IDLE; all latches go to 0.
  - m_ready = 0 while rst is high.
  - m_rvalid, t0_valid, t1_valid and busy are 0 while rst is high.
  - m_rdata = 0 while rst is high.
  - An abandoned transaction is dropped. A late target response arriving after reset is ignored.
- IDLE:
  - m_ready = 1 (combinational, gated by !rst).
  - On m_valid & m_ready: latch we, addr, wdata; set sel_q = m_addr[SEL_BIT]; go to REQ.
- REQ:
  - t{sel_q}_valid = 1; the other target's valid stays 0.
  - t_we/t_addr/t_wdata hold the latched values and stay stable.
  - Holding valid until ready is mandatory.
  - On t{sel_q}_ready: go to RESP.
  - Any rvalid seen in REQ is ignored.
- RESP:
  - Wait for t{sel_q}_rvalid. The unselected target's rvalid is ignored in all states.
  - On rvalid: rdata_q = we_q ? 0 : t{sel_q}_rdata; go to DONE.
- DONE:
  - m_rvalid = 1; m_rdata = rdata_q, held stable until accepted.
  - On m_rready: go to IDLE.
  - A new request is accepted no earlier than the cycle after the response handshake, since m_ready is low in DONE.
- Latency:
  - With target ready and rvalid asserted immediately and m_rready high, accept occurs at edge N, the target handshake at N+1, the response capture at N+2, and m_rvalid is high during cycle N+3. The return to IDLE happens at edge N+3.
  - Minimum period between successive requests is 4 cycles.
- m_rdata is 0 in every state except DONE.
- t_addr/t_wdata/t_we retain their last values in IDLE; targets must qualify them with valid.
- Stalls: an unbounded wait in REQ or RESP is permitted; the block has no timeout.

Test Plan:
- Read to target 0: m_addr=0x12, m_we=0; t0 ready on the first cycle, t0_rvalid with t0_rdata=0xBEEF -> t1_valid never high, m_rvalid high with m_rdata=0xBEEF exactly 3 cycles after accept.
- Write to target 1: m_addr=0x85, m_wdata=0x1234; t1 ack -> t1_valid=1, t_addr=0x85, t_wdata=0x1234, t_we=1; t1_ready delayed 3 cycles keeps t1_valid and data stable; m_rdata=0 on response.
- Backpressure: m_rready held low 5 cycles in DONE -> m_rvalid/m_rdata stable, m_ready=0, and a new m_valid is not accepted until after the response handshake.
- Cross-talk: in RESP for target 0, t1_rvalid pulses with t1_rdata=0xDEAD -> ignored; the later t0_rvalid with 0x0042 yields m_rdata=0x0042.
- Async reset in RESP: rst asserted mid-cycle -> immediately busy=0, t0_valid=0, m_rvalid=0; after release, m_ready=1 and a stray t0_rvalid causes no response.
- Back-to-back: two reads, 0x7F (target 0) then 0x80 (target 1) -> routed correctly; accept edges are 4 cycles apart with zero-wait targets.

Source files
------------

// File: rtl/mem_req_demux_1to2.sv
// mem_req_demux_1to2: routes one outstanding memory request from the core to the
// data RAM (target 0) or the MMIO space (target 1). A single address bit picks the
// target. The chosen target's response is returned to the master. The request is
// latched on accept, so the targets see stable t_* signals for the whole transaction.
module mem_req_demux_1to2 #(
    parameter int AW      = 8,
    parameter int DW      = 16,
    parameter int SEL_BIT = 7
) (
    input  logic          clk,
    input  logic          rst,
    // master request channel
    input  logic          m_valid,
    output logic          m_ready,
    input  logic          m_we,
    input  logic [AW-1:0] m_addr,
    input  logic [DW-1:0] m_wdata,
    // master response channel
    output logic          m_rvalid,
    input  logic          m_rready,
    output logic [DW-1:0] m_rdata,
    // target request channels (address/data shared, valid per target)
    output logic          t0_valid,
    input  logic          t0_ready,
    output logic          t1_valid,
    input  logic          t1_ready,
    output logic          t_we,
    output logic [AW-1:0] t_addr,
    output logic [DW-1:0] t_wdata,
    // target response channels
    input  logic          t0_rvalid,
    input  logic [DW-1:0] t0_rdata,
    input  logic          t1_rvalid,
    input  logic [DW-1:0] t1_rdata,
    // status
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic          we_q,    we_d;
    logic [AW-1:0] addr_q,  addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          sel_q,   sel_d;
    logic [DW-1:0] rdata_q, rdata_d;

    // Handshake signals of the latched target; the other target is never looked at.
    logic          sel_ready;
    logic          sel_rvalid;
    logic [DW-1:0] sel_rdata;

    assign sel_ready  = sel_q ? t1_ready  : t0_ready;
    assign sel_rvalid = sel_q ? t1_rvalid : t0_rvalid;
    assign sel_rdata  = sel_q ? t1_rdata  : t0_rdata;

    // Next-state and request/response latch update.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it
        // unassigned; otherwise synthesis infers a latch to hold the old value.
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        sel_d   = sel_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (m_valid && m_ready) begin
                    we_d    = m_we;
                    addr_d  = m_addr;
                    wdata_d = m_wdata;
                    sel_d   = m_addr[SEL_BIT];
                    state_d = REQ;
                end
            end
            REQ: begin
                // Response strobes arriving before the request handshake are ignored.
                if (sel_ready) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (sel_rvalid) begin
                    // Write acks carry no data; return zero to the master.
                    rdata_d = we_q ? '0 : sel_rdata;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (m_rready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and latch registers; reset drops any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            sel_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so all registers update together from
            // the values present before the edge, independent of statement order.
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            sel_q   <= sel_d;
            rdata_q <= rdata_d;
        end
    end

    // Handshake outputs decoded from the current state, held low while reset is high.
    always_comb begin
        m_ready  = 1'b0;
        m_rvalid = 1'b0;
        m_rdata  = '0;
        t0_valid = 1'b0;
        t1_valid = 1'b0;
        busy     = 1'b0;
        if (!rst) begin
            busy = (state_q != IDLE);
            case (state_q)
                IDLE: m_ready = 1'b1;
                REQ: begin
                    t0_valid = !sel_q;
                    t1_valid = sel_q;
                end
                DONE: begin
                    m_rvalid = 1'b1;
                    m_rdata  = rdata_q;
                end
                default: ;
            endcase
        end
    end

    // Request fields come straight from the latches; they keep their values in IDLE.
    assign t_we    = we_q;
    assign t_addr  = addr_q;
    assign t_wdata = wdata_q;

endmodule

// File: tb/tb_mem_req_demux_1to2.sv
// Self-checking bench for mem_req_demux_1to2: directed vector table, reset and
// back-to-back sequences, then random transactions against a transaction-level model.
module tb_mem_req_demux_1to2;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam int SEL_BIT = 7;

    logic          clk = 1'b0;
    logic          rst;
    logic          m_valid, m_ready, m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          m_rvalid, m_rready;
    logic [DW-1:0] m_rdata;
    logic          t0_valid, t0_ready, t1_valid, t1_ready;
    logic          t_we;
    logic [AW-1:0] t_addr;
    logic [DW-1:0] t_wdata;
    logic          t0_rvalid, t1_rvalid;
    logic [DW-1:0] t0_rdata, t1_rdata;
    logic          busy;

    int tests_run = 0;
    int tests_failed = 0;
    int cycle_cnt = 0;

    mem_req_demux_1to2 #(.AW(AW), .DW(DW), .SEL_BIT(SEL_BIT)) dut (
        .clk       (clk),
        .rst       (rst),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_we      (m_we),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_rvalid  (m_rvalid),
        .m_rready  (m_rready),
        .m_rdata   (m_rdata),
        .t0_valid  (t0_valid),
        .t0_ready  (t0_ready),
        .t1_valid  (t1_valid),
        .t1_ready  (t1_ready),
        .t_we      (t_we),
        .t_addr    (t_addr),
        .t_wdata   (t_wdata),
        .t0_rvalid (t0_rvalid),
        .t0_rdata  (t0_rdata),
        .t1_rvalid (t1_rvalid),
        .t1_rdata  (t1_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    // One transaction: request fields, target timing and the expected outcome.
    // exp_lat counts clock edges from the accept edge until m_rvalid is seen.
    typedef struct {
        string         name;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        int            rd;     // cycles t_ready stays low in REQ
        int            rv;     // cycles rvalid stays low in RESP
        int            rr;     // cycles m_rready stays low in DONE
        logic          xtalk;  // unselected target (and early selected) strobes rvalid
        logic          exp_sel;
        logic [DW-1:0] exp_resp;
        int            exp_lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_targets();
        t0_ready = 1'b0; t1_ready = 1'b0;
        t0_rvalid = 1'b0; t1_rvalid = 1'b0;
    endtask

    // Acts as master plus both targets for one transaction, reacting to the DUT.
    task automatic do_txn(input vec_t v, output int acc_cyc);
        int  cyc, lat, rw, sw;
        bit  hs, rsp;
        logic sel_v, oth_v;
        check({v.name, "/m_ready_idle"}, m_ready, 1);
        m_valid = 1'b1; m_we = v.we; m_addr = v.addr; m_wdata = v.wdata;
        step();
        acc_cyc = cycle_cnt;
        // Scramble master inputs so the targets must see the latched copy.
        m_valid = 1'b0; m_we = ~v.we; m_addr = ~v.addr; m_wdata = ~v.wdata;
        cyc = 0; lat = -1; rw = 0; sw = 0; hs = 0; rsp = 0;
        while (cyc < 40) begin
            if (m_rvalid === 1'b1) begin
                lat = cyc;
                break;
            end
            sel_v = v.exp_sel ? t1_valid : t0_valid;
            oth_v = v.exp_sel ? t0_valid : t1_valid;
            check({v.name, "/other_valid"}, oth_v, 0);
            check({v.name, "/m_rdata_idle"}, m_rdata, 0);
            check({v.name, "/busy"}, busy, 1);
            if (!hs) begin
                check({v.name, "/sel_valid"}, sel_v, 1);
                check({v.name, "/t_addr"}, t_addr, v.addr);
                check({v.name, "/t_wdata"}, t_wdata, v.wdata);
                check({v.name, "/t_we"}, t_we, v.we);
                if (v.exp_sel) begin
                    t1_ready = (rw == v.rd); t1_rvalid = v.xtalk; t1_rdata = 16'hDEAD;
                end else begin
                    t0_ready = (rw == v.rd); t0_rvalid = v.xtalk; t0_rdata = 16'hDEAD;
                end
            end else begin
                check({v.name, "/sel_valid_low"}, sel_v, 0);
                if (v.exp_sel) begin
                    t1_rvalid = !rsp && (sw == v.rv);
                    t1_rdata  = t1_rvalid ? v.rdata : 16'hDEAD;
                end else begin
                    t0_rvalid = !rsp && (sw == v.rv);
                    t0_rdata  = t0_rvalid ? v.rdata : 16'hDEAD;
                end
            end
            // The unselected target strobes a bogus response.
            if (v.exp_sel) begin
                t0_rvalid = v.xtalk & 1'($urandom); t0_rdata = 16'hDEAD;
            end else begin
                t1_rvalid = v.xtalk & 1'($urandom); t1_rdata = 16'hDEAD;
            end
            step();
            cyc++;
            clear_targets();
            if (!hs) begin
                if (rw == v.rd) hs = 1; else rw++;
            end else if (!rsp) begin
                if (sw == v.rv) rsp = 1; else sw++;
            end
        end
        check({v.name, "/latency"}, lat, v.exp_lat);
        // Response phase: hold off m_rready, offer a competing request meanwhile.
        for (int k = 0; k <= v.rr; k++) begin
            check({v.name, "/m_rvalid"}, m_rvalid, 1);
            check({v.name, "/m_rdata"}, m_rdata, v.exp_resp);
            check({v.name, "/m_ready_done"}, m_ready, 0);
            m_valid  = 1'($urandom);
            m_addr   = 8'($urandom);
            m_rready = (k == v.rr);
            step();
        end
        m_rready = 1'b0; m_valid = 1'b0;
        check({v.name, "/m_rvalid_after"}, m_rvalid, 0);
        check({v.name, "/m_rdata_after"}, m_rdata, 0);
        check({v.name, "/busy_after"}, busy, 0);
        check({v.name, "/m_ready_after"}, m_ready, 1);
    endtask

    vec_t vecs[6];
    vec_t rv_t;
    int   acc, prev_acc;

    initial begin
        rst = 1'b1;
        m_valid = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0; m_rready = 1'b0;
        clear_targets();
        t0_rdata = '0; t1_rdata = '0;

        // Reset state: everything low even with a request pending.
        m_valid = 1'b1;
        repeat (2) step();
        check("rst/m_ready", m_ready, 0);
        check("rst/busy", busy, 0);
        check("rst/m_rvalid", m_rvalid, 0);
        check("rst/t0_valid", t0_valid, 0);
        check("rst/t1_valid", t1_valid, 0);
        check("rst/m_rdata", m_rdata, 0);
        m_valid = 1'b0;
        #3 rst = 1'b0;
        step();
        check("rst/m_ready_rel", m_ready, 1);
        check("rst/t_addr", t_addr, 0);
        check("rst/t_wdata", t_wdata, 0);
        check("rst/t_we", t_we, 0);

        // Directed vectors from the test plan.
        vecs[0] = '{"rd_t0",  1'b0, 8'h12, 16'h0000, 16'hBEEF, 0, 0, 0, 1'b0, 1'b0, 16'hBEEF, 2};
        vecs[1] = '{"wr_t1",  1'b1, 8'h85, 16'h1234, 16'h7777, 3, 1, 0, 1'b0, 1'b1, 16'h0000, 6};
        vecs[2] = '{"bkpr",   1'b0, 8'h40, 16'h0000, 16'hA5A5, 0, 0, 5, 1'b0, 1'b0, 16'hA5A5, 2};
        vecs[3] = '{"xtalk",  1'b0, 8'h20, 16'h0000, 16'h0042, 1, 2, 0, 1'b1, 1'b0, 16'h0042, 5};
        vecs[4] = '{"b2b_a",  1'b0, 8'h7F, 16'h0000, 16'h1111, 0, 0, 0, 1'b0, 1'b0, 16'h1111, 2};
        vecs[5] = '{"b2b_b",  1'b0, 8'h80, 16'h0000, 16'h2222, 0, 0, 0, 1'b0, 1'b1, 16'h2222, 2};
        prev_acc = 0;
        for (int i = 0; i < 6; i++) begin
            do_txn(vecs[i], acc);
            if (i == 5) check("b2b/accept_spacing", acc - prev_acc, 4);
            prev_acc = acc;
        end

        // Async reset in RESP: drop the transaction mid-cycle.
        m_valid = 1'b1; m_we = 1'b0; m_addr = 8'h10;
        step();
        m_valid = 1'b0;
        t0_ready = 1'b1;
        step();
        t0_ready = 1'b0;
        check("arst/busy_in_resp", busy, 1);
        #3 rst = 1'b1;
        #1;
        check("arst/busy", busy, 0);
        check("arst/t0_valid", t0_valid, 0);
        check("arst/m_rvalid", m_rvalid, 0);
        check("arst/m_ready", m_ready, 0);
        @(posedge clk);
        #3 rst = 1'b0;
        step();
        check("arst/m_ready_rel", m_ready, 1);
        t0_rvalid = 1'b1; t0_rdata = 16'h5555;
        for (int k = 0; k < 3; k++) begin
            step();
            check("arst/stray_m_rvalid", m_rvalid, 0);
            check("arst/stray_busy", busy, 0);
        end
        t0_rvalid = 1'b0;

        // Random transactions; expected routing and data follow from the address
        // map (upper half of the address space is MMIO) and the read/write rule.
        for (int i = 0; i < 40; i++) begin
            rv_t.name     = "rand";
            rv_t.we       = 1'($urandom);
            rv_t.addr     = 8'($urandom);
            rv_t.wdata    = 16'($urandom);
            rv_t.rdata    = 16'($urandom);
            rv_t.rd       = $urandom_range(0, 3);
            rv_t.rv       = $urandom_range(0, 3);
            rv_t.rr       = $urandom_range(0, 3);
            rv_t.xtalk    = 1'($urandom);
            rv_t.exp_sel  = (rv_t.addr >= 8'd128);
            rv_t.exp_resp = rv_t.we ? 16'h0000 : rv_t.rdata;
            rv_t.exp_lat  = 2 + rv_t.rd + rv_t.rv;
            do_txn(rv_t, acc);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
